gray: RTL and testbench
=======================

Name: gray

Overview:
- Synchronous 3-bit Gray-code counter with enable and a sticky overflow flag.
- Advances one Gray code step per enabled clock edge.
- Asserts Overflow when the count wraps from the last code back to zero.
- Used as a standalone counter or sequencer block, clocked from the system clock.

Parameters:
- WIDTH, 3, counter width in bits. Default and tested value is 3. Output width tracks WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous active-low reset. 0 = reset, sampled on the Clk rising edge.
- En  input  1  count enable, active-high.
- Output  output  WIDTH  current Gray-code count value, registered.
- Overflow  output  1  sticky wrap flag, registered.

Behaviour:
- Clocking: single clock domain. All state changes on posedge Clk only. No asynchronous paths.
- Reset:
  - Reset is synchronous and active-low.
  - When Reset==0 at a rising edge: internal count = 0, Output = 0, Overflow = 0.
  - Reset has priority over En.
  - Before the first reset edge, outputs are undefined; the bench must apply reset first.
- Internal state: binary counter bin[WIDTH-1:0] plus the Overflow register.
  - Output = bin ^ (bin >> 1), either combinational from the registered bin, or registered directly.
  - Output must change only right after a clock edge; no glitch-visible logic from inputs.
- Counting: when Reset==1 and En==1 at a rising edge, bin <= bin + 1, modulo 2^WIDTH.
- Sequence for WIDTH=3: 000, 001, 011, 010, 110, 111, 101, 100, 000, ...
  - Exactly one bit of Output changes per step, including the wrap step 100 -> 000.
- Hold: when Reset==1 and En==0, bin and Overflow hold their values.
- Overflow:
  - Set to 1 on the enabled edge where bin goes from all-ones to zero, i.e. Output goes 100 -> 000 for WIDTH=3.
  - Takes effect in the same cycle that Output becomes 000.
  - Once set, stays 1 through further counting, further wraps and En==0.
  - Cleared only by reset.
- Latency: one clock from an enabled edge to the new Output value. Overflow has the same latency.
- Reset mid-count: Output returns to 000 and Overflow to 0 on that edge, regardless of En or current value. Counting resumes from 000 on the next enabled edge.
- Deassertion: the first edge with Reset==1 and En==1 produces Output = 001.

Test Plan:
- Hold Reset=0 for several edges with En=1 -> Output stays 000 and Overflow stays 0.
- Release Reset=1 with En=1, count 7 edges -> Output steps 001, 011, 010, 110, 111, 101, 100, with Overflow=0 throughout.
- 8th enabled edge -> Output=000 and Overflow=1. Continue 10 more edges -> Output keeps cycling and Overflow stays 1, including across the second wrap.
- Drop En=0 while Output=010 for 5 edges -> Output holds 010 and Overflow holds its value. Raise En=1 -> the next edge gives 110.
- With Overflow=1 and Output=111, drive Reset=0 for one edge with En=1 -> Output=000 and Overflow=0. Release reset -> the next edge gives 001.
- Every step of a full cycle -> Hamming distance between consecutive Output values is exactly 1.

Source files
------------

// File: rtl/gray.sv
// Gray-code counter with enable and a sticky wrap flag.
// A binary count is kept internally; the Gray output is registered so it only moves on a clock edge.
module gray #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_overflow;
    logic [WIDTH-1:0] w_binNext;
    logic [WIDTH-1:0] w_grayNext;
    logic             w_wrap;

    // Gray code of the next count is precomputed so Output can be a plain flop.
    always_comb begin
        w_binNext  = r_bin + 1'b1;
        w_grayNext = w_binNext ^ (w_binNext >> 1);
        w_wrap     = &r_bin;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_bin      <= '0;
            r_gray     <= '0;
            r_overflow <= 1'b0;
        end else if (En) begin
            r_bin  <= w_binNext;
            r_gray <= w_grayNext;
            if (w_wrap) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign Output   = r_gray;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_gray.sv
// Self-checking bench for the gray counter: a reference model pushes expected
// values to a scoreboard as stimulus is driven, and they are popped after each edge.
module tb_gray;

    localparam int WIDTH = 3;

    logic             Clk;
    logic             Reset;
    logic             En;
    logic [WIDTH-1:0] Output;
    logic             Overflow;

    int testsRun;
    int testsFailed;

    logic [WIDTH-1:0] grayTable [8];
    logic [WIDTH-1:0] expOutQ [$];
    logic             expOvfQ [$];
    logic             stepQ [$];
    int               modelBin;
    logic             modelOvf;
    logic [WIDTH-1:0] prevOut;

    gray #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Output   (Output),
        .Overflow (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, update the model, push expectations, then compare after the edge.
    task automatic applyStimulus(input logic rst, input logic en, input string tag);
        logic [WIDTH-1:0] expOut;
        logic             expOvf;
        logic             isStep;
        @(negedge Clk);
        Reset = rst;
        En    = en;
        isStep = rst && en;
        if (!rst) begin
            modelBin = 0;
            modelOvf = 1'b0;
        end else if (en) begin
            if (modelBin == 7) modelOvf = 1'b1;
            modelBin = (modelBin + 1) % 8;
        end
        expOutQ.push_back(grayTable[modelBin]);
        expOvfQ.push_back(modelOvf);
        stepQ.push_back(isStep);
        @(posedge Clk);
        #1;
        expOut = expOutQ.pop_front();
        expOvf = expOvfQ.pop_front();
        isStep = stepQ.pop_front();
        checkOutput({tag, "_out"}, 32'(Output), 32'(expOut));
        checkOutput({tag, "_ovf"}, 32'(Overflow), 32'(expOvf));
        if (isStep) begin
            checkOutput({tag, "_hamming"}, 32'($countones(Output ^ prevOut)), 32'd1);
        end
        prevOut = Output;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        grayTable[0] = 3'b000; grayTable[1] = 3'b001;
        grayTable[2] = 3'b011; grayTable[3] = 3'b010;
        grayTable[4] = 3'b110; grayTable[5] = 3'b111;
        grayTable[6] = 3'b101; grayTable[7] = 3'b100;
        modelBin = 0;
        modelOvf = 1'b0;
        prevOut  = '0;
        Reset    = 1'b0;
        En       = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "reset_hold");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, "count_first");
        applyStimulus(1'b1, 1'b1, "first_wrap");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, "count_sticky");
        for (int i = 0; i < 8 && modelBin != 3; i++) applyStimulus(1'b1, 1'b1, "to_010");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, "hold");
        applyStimulus(1'b1, 1'b1, "resume");
        for (int i = 0; i < 8 && modelBin != 5; i++) applyStimulus(1'b1, 1'b1, "to_111");
        applyStimulus(1'b0, 1'b1, "mid_reset");
        applyStimulus(1'b1, 1'b1, "after_reset");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, "full_cycle");
        applyStimulus(1'b1, 1'b0, "final_hold");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
